// File: rtl/ctr_down_casc_if.sv
// Underflow event channel of the cascaded down-counter.
// The counter drives the event and its sticky lost flag; the consumer
// answers with evt_ready to accept a pending event.
interface ctr_down_casc_if;
  logic evt_valid;
  logic evt_ready;
  logic evt_lost;

  modport master (
    output evt_valid,
    output evt_lost,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_lost,
    output evt_ready
  );
endinterface

// File: rtl/ctr_down_casc.sv
// Cascaded down-counter/timer built from 4-bit slices joined by a borrow
// chain. An underflow (a count step taken at zero) either reloads from the
// reload register or wraps to all ones, and raises an event that the
// consumer acknowledges through a valid/ready handshake. An underflow that
// arrives while an earlier event is still unaccepted sets a sticky lost flag.
module ctr_down_casc #(
  parameter int               WIDTH          = 16,
  parameter logic [WIDTH-1:0] RELOAD_DEFAULT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             enp,
  input  logic             ent,
  input  logic             autoreload,
  output logic [WIDTH-1:0] q,
  output logic             bo,
  ctr_down_casc_if.master  evt
);

  localparam int SLICES = WIDTH / 4;

  logic [WIDTH-1:0] rld;
  logic [WIDTH-1:0] q_dec;
  logic             step;
  logic             uf;
  logic             chain;

  // A count step needs both enables and loses to clr and ld.
  assign step = enp & ent & ~clr & ~ld;

  // The cascade output only looks at ent and the current count, never enp.
  assign bo = ent & (q == '0);

  // Walk the borrow chain slice by slice: each slice decrements only when the
  // step is active and every slice below it is zero. Whatever borrow survives
  // past the top slice means the whole count was zero, which is the underflow.
  always_comb begin
    q_dec = q;
    chain = step;
    for (int k = 0; k < SLICES; k++) begin
      if (chain) begin
        q_dec[4*k +: 4] = q[4*k +: 4] - 4'd1;
      end
      chain = chain & (q[4*k +: 4] == 4'd0);
    end
    uf = chain;
  end

  // Count and reload register, with priority clr over ld over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      rld <= RELOAD_DEFAULT;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q   <= d;
      rld <= d;
    end else if (step) begin
      q <= (uf && autoreload) ? rld : q_dec;
    end
  end

  // Event handshake: hold until accepted, and flag an overrun as lost unless
  // the pending event is being accepted on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt.evt_valid <= 1'b0;
      evt.evt_lost  <= 1'b0;
    end else begin
      evt.evt_valid <= uf | (evt.evt_valid & ~evt.evt_ready);
      if (clr) begin
        evt.evt_lost <= 1'b0;
      end else if (uf && evt.evt_valid && !evt.evt_ready) begin
        evt.evt_lost <= 1'b1;
      end
    end
  end

endmodule
